// File: rtl/pe_out_collector.sv
// Sink stage for a PE output port: stamps and buffers data tokens in a FWFT FIFO,
// returns registered backpressure, and tracks accepted/dropped token counts.
module pe_out_collector #(
    parameter int DEPTH   = 8,
    parameter int STAMP_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [35:0]                PE_Inport,
    output logic                       Pre_PE_Bp,
    input  logic                       rd_en,
    output logic                       rd_valid,
    output logic [2:0]                 rd_vbl,
    output logic [31:0]                rd_data,
    output logic [STAMP_W-1:0]         rd_stamp,
    output logic [$clog2(DEPTH+1)-1:0] level,
    input  logic [15:0]                expected,
    output logic [15:0]                tok_count,
    output logic                       done,
    output logic                       overflow,
    output logic [7:0]                 drop_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    localparam int EW = 3 + 32 + STAMP_W;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] BP_MAX   = LW'(DEPTH - 2);

    logic [EW-1:0]      mem_q [DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      level_q, level_d;
    logic [STAMP_W-1:0] stamp_q, stamp_d;
    logic [15:0]        tok_count_q, tok_count_d;
    logic [7:0]         drop_count_q, drop_count_d;
    logic               overflow_q, overflow_d;
    logic               pre_pe_bp_q, pre_pe_bp_d;

    logic          is_data;
    logic          full;
    logic          wr;
    logic          pop;
    logic          drop;
    logic [EW-1:0] head;

    always_comb begin
        is_data      = (PE_Inport[35:33] != 3'b000) && !PE_Inport[32];
        full         = (level_q == FULL_LVL);
        pop          = rd_en && (level_q != '0);
        // When full, a same-cycle pop frees the slot the new token lands in.
        wr           = is_data && (!full || rd_en);
        drop         = is_data && full && !rd_en;

        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        tok_count_d  = tok_count_q;
        drop_count_d = drop_count_q;
        overflow_d   = overflow_q;
        stamp_d      = stamp_q + STAMP_W'(1);

        if (wr) begin
            wr_ptr_d    = wr_ptr_q + PW'(1);
            tok_count_d = tok_count_q + 16'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (wr && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !wr) begin
            level_d = level_q - LW'(1);
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != 8'hFF) begin
                drop_count_d = drop_count_q + 8'd1;
            end
        end

        // One slot of slack covers the token launched while the producer sees the drop.
        pre_pe_bp_d = (level_d <= BP_MAX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            stamp_q      <= '0;
            tok_count_q  <= '0;
            drop_count_q <= '0;
            overflow_q   <= 1'b0;
            pre_pe_bp_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            stamp_q      <= stamp_d;
            tok_count_q  <= tok_count_d;
            drop_count_q <= drop_count_d;
            overflow_q   <= overflow_d;
            pre_pe_bp_q  <= pre_pe_bp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr && !reset) begin
            mem_q[wr_ptr_q] <= {PE_Inport[35:33], PE_Inport[31:0], stamp_q};
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign rd_vbl     = head[EW-1 -: 3];
    assign rd_data    = head[STAMP_W +: 32];
    assign rd_stamp   = head[STAMP_W-1:0];
    assign rd_valid   = (level_q != '0);
    assign level      = level_q;
    assign tok_count  = tok_count_q;
    assign drop_count = drop_count_q;
    assign overflow   = overflow_q;
    assign Pre_PE_Bp  = pre_pe_bp_q;
    assign done       = (tok_count_q == expected) && (expected != 16'd0);

endmodule

// File: tb/tb_pe_out_collector.sv
// Directed bench for pe_out_collector (DEPTH=4): classification, stamping,
// overflow/drop, full-with-pop, streaming and mid-run reset.
module tb_pe_out_collector;

    logic        clk = 1'b0;
    logic        reset;
    logic [35:0] PE_Inport;
    logic        Pre_PE_Bp;
    logic        rd_en;
    logic        rd_valid;
    logic [2:0]  rd_vbl;
    logic [31:0] rd_data;
    logic [15:0] rd_stamp;
    logic [2:0]  level;
    logic [15:0] expected;
    logic [15:0] tok_count;
    logic        done;
    logic        overflow;
    logic [7:0]  drop_count;

    int n_checks = 0;
    int n_fail   = 0;

    pe_out_collector #(.DEPTH(4), .STAMP_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .PE_Inport  (PE_Inport),
        .Pre_PE_Bp  (Pre_PE_Bp),
        .rd_en      (rd_en),
        .rd_valid   (rd_valid),
        .rd_vbl     (rd_vbl),
        .rd_data    (rd_data),
        .rd_stamp   (rd_stamp),
        .level      (level),
        .expected   (expected),
        .tok_count  (tok_count),
        .done       (done),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [35:0] dtok(input logic [31:0] d);
        return {3'b110, 1'b0, d};
    endfunction

    // Leaves the bench in the first cycle after release (stamp == 0 here).
    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [15:0] prev_stamp;

    initial begin
        reset     = 1'b1;
        PE_Inport = '0;
        rd_en     = 1'b0;
        expected  = 16'd0;

        // Reset state
        do_reset();
        chk("rst_level", level, 0);
        chk("rst_tok", tok_count, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_bp", Pre_PE_Bp, 0);

        // Single token at cycle 3
        expected = 16'd1;
        tick();
        chk("bp_after_release", Pre_PE_Bp, 1);
        tick();
        tick();
        PE_Inport = dtok(32'd7);
        tick();
        PE_Inport = '0;
        chk("t1_valid", rd_valid, 1);
        chk("t1_vbl", rd_vbl, 3'b110);
        chk("t1_data", rd_data, 7);
        chk("t1_stamp", rd_stamp, 3);
        chk("t1_tok", tok_count, 1);
        chk("t1_done", done, 1);
        expected = 16'd2;
        #1;
        chk("t1_done_live", done, 0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("t1_pop_level", level, 0);
        chk("t1_pop_valid", rd_valid, 0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("underflow_level", level, 0);

        // Control token and bubble are ignored
        do_reset();
        PE_Inport = {3'b110, 1'b1, 32'd5};
        tick();
        PE_Inport = {3'b000, 1'b0, 32'd9};
        tick();
        PE_Inport = '0;
        tick();
        chk("t2_level", level, 0);
        chk("t2_tok", tok_count, 0);
        chk("t2_ovf", overflow, 0);
        chk("t2_valid", rd_valid, 0);

        // Fill past full without reads: 1..6
        for (int i = 1; i <= 6; i++) begin
            PE_Inport = dtok(32'(i));
            tick();
            chk($sformatf("t3_level_%0d", i), level, (i > 4) ? 4 : i);
            chk($sformatf("t3_bp_%0d", i), Pre_PE_Bp, (i <= 2) ? 1 : 0);
            chk($sformatf("t3_drop_%0d", i), drop_count, (i > 4) ? i - 4 : 0);
        end
        PE_Inport = '0;
        chk("t3_ovf", overflow, 1);
        chk("t3_tok", tok_count, 4);
        chk("t3_valid_full", rd_valid, 1);
        chk("t3_head", rd_data, 1);

        // Full with simultaneous pop and write
        PE_Inport = dtok(32'd77);
        rd_en     = 1'b1;
        tick();
        PE_Inport = '0;
        rd_en     = 1'b0;
        chk("t4_level", level, 4);
        chk("t4_drop", drop_count, 2);
        chk("t4_head", rd_data, 2);
        chk("t4_tok", tok_count, 5);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] exp_d;
            exp_d = (i == 3) ? 32'd77 : 32'(i + 2);
            chk($sformatf("t4_rd_%0d", i), rd_data, exp_d);
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
            chk($sformatf("t4_lvl_%0d", i), level, 3 - i);
            chk($sformatf("t4_bp_%0d", i), Pre_PE_Bp, (3 - i <= 2) ? 1 : 0);
        end
        chk("t4_empty", rd_valid, 0);

        // Streaming with rd_en held high
        rd_en = 1'b1;
        prev_stamp = '0;
        for (int i = 0; i < 10; i++) begin
            PE_Inport = dtok(32'(100 + i));
            tick();
            chk($sformatf("t5_data_%0d", i), rd_data, 100 + i);
            chk($sformatf("t5_level_%0d", i), level, 1);
            chk($sformatf("t5_bp_%0d", i), Pre_PE_Bp, 1);
            if (i > 0) chk($sformatf("t5_stamp_%0d", i), rd_stamp, prev_stamp + 16'd1);
            prev_stamp = rd_stamp;
        end
        PE_Inport = '0;
        tick();
        rd_en = 1'b0;
        chk("t5_drain", level, 0);
        chk("t5_tok", tok_count, 15);
        expected = 16'd15;
        #1;
        chk("t5_done", done, 1);
        expected = 16'd16;
        #1;
        chk("t5_done_live", done, 0);

        // Mid-run reset with level 3 and overflow set
        for (int i = 0; i < 5; i++) begin
            PE_Inport = dtok(32'(200 + i));
            tick();
        end
        PE_Inport = '0;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("t6_pre_level", level, 3);
        chk("t6_pre_ovf", overflow, 1);
        reset = 1'b1;
        tick();
        chk("t6_level", level, 0);
        chk("t6_ovf", overflow, 0);
        chk("t6_tok", tok_count, 0);
        chk("t6_drop", drop_count, 0);
        chk("t6_bp", Pre_PE_Bp, 0);
        chk("t6_valid", rd_valid, 0);
        reset = 1'b0;
        PE_Inport = dtok(32'd55);
        tick();
        PE_Inport = '0;
        chk("t6_bp_back", Pre_PE_Bp, 1);
        chk("t6_level_new", level, 1);
        chk("t6_data_new", rd_data, 55);
        chk("t6_stamp0", rd_stamp, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pe_out_collector.md
# pe_out_collector

Downstream sink stage for a PE array: consumes the 36-bit token stream leaving a `PE_top` output port. It timestamps and buffers valid data tokens in a FIFO for a host or bench reader. It returns backpressure to the producing PE through its `Post_PE_Bp` input, and counts tokens against an expected total so a run can be declared complete.

## Interface
Parameters:
- DEPTH, 8 — FIFO entries; power of two, ≥4.
- STAMP_W, 16 — timestamp width in bits.

Ports:
- clk  in  1  — single clock; all logic is on the rising edge.
- reset  in  1  — synchronous, active-high.
- PE_Inport  in  36  — token from the producing PE_Outport0; [35:33] vbl, [32] ctl, [31:0] data.
- Pre_PE_Bp  out  1  — ready to the producer's Post_PE_Bp; 1 means the producer may send.
- rd_en  in  1  — pop the head entry.
- rd_valid  out  1  — FIFO non-empty; head fields are valid.
- rd_vbl  out  3  — vbl of the head entry.
- rd_data  out  32  — data of the head entry.
- rd_stamp  out  STAMP_W  — cycle stamp of the head entry.
- level  out  $clog2(DEPTH+1)  — current occupancy.
- expected  in  16  — number of data tokens expected in the run.
- tok_count  out  16  — data tokens accepted so far.
- done  out  1  — tok_count == expected and expected != 0.
- overflow  out  1  — sticky; set when a data token is dropped.
- drop_count  out  8  — count of dropped data tokens; saturates at 255.

## Operation
- Token classification each cycle:
  - Data token: vbl != 3'b000 and ctl == 0.
  - Control token: vbl != 0 and ctl == 1. Ignored; not stored, not counted.
  - Bubble: vbl == 0. Ignored.
- Stamp counter:
  - Free-running, STAMP_W bits; wraps from 2^STAMP_W−1 to 0.
  - Equals 0 in the first cycle after reset deasserts and increments every cycle.
  - Each stored entry records the stamp value current in the cycle it is sampled.
- Write: a data token is written when level < DEPTH, or when level == DEPTH and rd_en is high in the same cycle (the simultaneous pop frees a slot). On write, tok_count increments and wraps at 16 bits.
- Drop: a data token arriving while level == DEPTH and rd_en is low is discarded. overflow sets and drop_count increments (saturating). tok_count does not change.
- Read:
  - First-word fall-through: rd_vbl, rd_data and rd_stamp always show the head entry; they are don't-care while rd_valid == 0.
  - rd_en with rd_valid == 1 pops the head.
  - rd_en while empty is ignored, with no underflow and no state change.
- Simultaneous write and read with level ≥ 1: level is unchanged and order is preserved. At level 0, a read is ignored and the write proceeds.
- Backpressure: Pre_PE_Bp is registered, with Pre_PE_Bp <= (level_next ≤ DEPTH−2). This leaves one spare slot to absorb the token the producer may launch in the cycle it samples the deassertion.
- done: combinational compare of tok_count against the live expected input. Changing expected mid-run re-evaluates done immediately.

## Timing
- Reset, sampled at a rising edge with reset high, forces:
  - level, tok_count, drop_count and stamp = 0;
  - overflow = 0, done = 0, rd_valid = 0;
  - Pre_PE_Bp = 0.
- First cycle after reset release: Pre_PE_Bp = 1.
- Reset asserted mid-operation discards all buffered entries; no read data survives it.
- Write latency: a token sampled at edge k appears on rd_* with rd_valid = 1 after edge k, i.e. readable in cycle k+1.
- Pop: rd_en sampled at edge k; the next head is presented after edge k.
- Backpressure latency:
  - Pre_PE_Bp falls one edge after level_next reaches DEPTH−1.
  - It rises one edge after level_next returns to ≤ DEPTH−2.
- Occupancy:
  - Full: level == DEPTH; rd_valid stays 1.
  - Empty: level == 0; rd_valid = 0.
- Pointers: log2(DEPTH) bits, wrap naturally.

## Test plan
- Reset, then inject {3'b110,1'b0,32'd7} at cycle 3 → rd_valid=1 at cycle 4 with rd_vbl=110, rd_data=7, rd_stamp=3; tok_count=1; with expected=1, done=1.
- Inject {3'b110,1'b1,32'd5}, then {3'b000,1'b0,32'd9} → nothing stored; level=0, tok_count=0, overflow=0.
- DEPTH=4, no reads, one data token per cycle with data 1..6 → Pre_PE_Bp falls after level reaches 3. Tokens 5 and 6 are dropped; overflow=1, drop_count=2, level=4. Reads then return 1,2,3,4 in order.
- Hold the FIFO full and inject a data token with rd_en=1 in the same cycle → no drop; level stays 4; head advances; the new token is last.
- Stream 10 tokens with rd_en held high → each read sees its value one cycle after injection, level ≤ 1, stamps strictly increase by 1, Pre_PE_Bp stays 1.
- Assert reset with level=3 and overflow=1 → all counters, level, overflow and Pre_PE_Bp are 0 after the edge. Pre_PE_Bp returns to 1 one cycle after release, and stamp restarts at 0.
